// File: rtl/seg7_pkg.sv
// Shared types and constants for the decimal 7-segment display stage.
package seg7_pkg;

  localparam int unsigned HALF_W       = 16;
  localparam int unsigned BCD_DIGITS   = 5;
  localparam int unsigned BCD_W        = 4 * BCD_DIGITS;
  localparam int unsigned SHIFT_CYCLES = 16;
  localparam int unsigned CNT_W        = $clog2(SHIFT_CYCLES);

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  // One committed half: four BCD digits plus the over-range flag.
  typedef struct packed {
    logic        sat;
    logic [15:0] digits;
  } disp_t;

  function automatic logic [7:0] digit_to_seg(input logic [3:0] d);
    logic [7:0] seg;
    case (d)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Values above 9999 clamp to 9999 and raise the dp flag.
  function automatic disp_t to_disp(input logic [BCD_W-1:0] bcd);
    disp_t d;
    if (bcd[BCD_W-1:HALF_W] != 4'd0) begin
      d.sat    = 1'b1;
      d.digits = 16'h9999;
    end else begin
      d.sat    = 1'b0;
      d.digits = bcd[HALF_W-1:0];
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit double-dabble datapath; one bit consumed per step.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              start,
  input  logic              step,
  input  logic [HALF_W-1:0] bin,
  output logic [BCD_W-1:0]  bcd
);

  logic [HALF_W-1:0] sr_q;
  logic [BCD_W-1:0]  acc_q;
  logic [BCD_W-1:0]  acc_adj_c;

  always_comb begin
    acc_adj_c = acc_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj_c[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      sr_q  <= '0;
      acc_q <= '0;
    end else if (start) begin
      sr_q  <= bin;
      acc_q <= '0;
    end else if (step) begin
      {acc_q, sr_q} <= (BCD_W + HALF_W)'({acc_adj_c, sr_q} << 1);
    end
  end

  assign bcd = acc_q;

endmodule

// File: rtl/seg7_dec_scan.sv
// Binary-to-decimal 8-digit multiplexed 7-segment driver.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros per half.
module seg7_dec_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        o_busy,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             busy_d;
  logic             start_c, step_c, commit_c;
  logic [BCD_W-1:0] bcd_l, bcd_r;
  disp_t            disp_l_q, disp_r_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    start_c   = 1'b0;
    step_c    = 1'b0;
    commit_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          start_c   = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        step_c    = 1'b1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == CNT_W'(SHIFT_CYCLES - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit_c = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      o_busy    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      o_busy    <= busy_d;
    end
  end

  bin2bcd_seq u_conv_l (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .start  (start_c),
    .step   (step_c),
    .bin    (in_data[31:16]),
    .bcd    (bcd_l)
  );

  bin2bcd_seq u_conv_r (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .start  (start_c),
    .step   (step_c),
    .bin    (in_data[15:0]),
    .bcd    (bcd_r)
  );

  // Scan reads only these, so a conversion in flight never tears the display.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      disp_l_q <= '0;
      disp_r_q <= '0;
    end else if (commit_c) begin
      disp_l_q <= to_disp(bcd_l);
      disp_r_q <= to_disp(bcd_r);
    end
  end

  logic [DIV_W-1:0] div_q;
  logic [2:0]       idx_q;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  disp_t      half_c;
  logic [1:0] pos_c;
  logic [3:0] nib_c;
  logic [7:0] seg_c;
  logic [7:0] sel_c;

  always_comb begin
    half_c = idx_q[2] ? disp_l_q : disp_r_q;
    pos_c  = idx_q[1:0];
    nib_c  = 4'(half_c.digits >> {pos_c, 2'b00});
    seg_c  = digit_to_seg(nib_c);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Ones digit is never blanked; saturated halves always show 9999.
    if (!half_c.sat) begin
      case (pos_c)
        2'd3:    if (half_c.digits[15:12] == 4'd0)  seg_c = SEG_BLANK;
        2'd2:    if (half_c.digits[15:8]  == 8'd0)  seg_c = SEG_BLANK;
        2'd1:    if (half_c.digits[15:4]  == 12'd0) seg_c = SEG_BLANK;
        default: ;
      endcase
    end
`endif
    if (half_c.sat && (pos_c == 2'd3)) seg_c[7] = 1'b0;
    sel_c = ~(8'(1) << idx_q);
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      o_seg <= SEG_BLANK;
      o_sel <= 8'hFF;
    end else begin
      o_seg <= seg_c;
      o_sel <= sel_c;
    end
  end

endmodule

// File: tb/tb_seg7_dec_scan.sv
// Scoreboard bench for seg7_dec_scan; two instances with scan dividers 4 and 1.
module tb_seg7_dec_scan;

  localparam int unsigned DIV = 4;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        o_busy, o_busy1;
  logic [7:0]  o_seg, o_sel, o_seg1, o_sel1;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic [63:0] exp_q[$];
  logic [63:0] cur_exp = '0;

  always #5 in_clk = ~in_clk;

  seg7_dec_scan #(.SCAN_DIV(DIV)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_data(in_data), .in_valid(in_valid),
    .o_busy(o_busy), .o_seg(o_seg), .o_sel(o_sel)
  );

  seg7_dec_scan #(.SCAN_DIV(1)) dut1 (
    .in_clk(in_clk), .in_rst(in_rst), .in_data(in_data), .in_valid(in_valid),
    .o_busy(o_busy1), .o_seg(o_seg1), .o_sel(o_sel1)
  );

  always @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  function automatic logic [7:0] seg_code(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;  default: return 8'hFF;
    endcase
  endfunction

  // Expected segment byte for every digit, digit i at bits [8i+7:8i].
  function automatic logic [63:0] model_disp(input logic [31:0] d);
    logic [63:0] r;
    int          v, p;
    logic        sat, blank;
    r = '0;
    for (int h = 0; h < 2; h++) begin
      v   = (h == 1) ? int'(d[31:16]) : int'(d[15:0]);
      sat = (v > 9999);
      if (sat) v = 9999;
      p = 1;
      for (int k = 0; k < 4; k++) begin
        blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank = !sat && (k > 0) && (v < p);
`endif
        r[(h*4+k)*8 +: 8] = blank ? 8'hFF : seg_code((v / p) % 10);
        if (sat && k == 3) r[(h*4+k)*8 + 7] = 1'b0;
        p = p * 10;
      end
    end
    return r;
  endfunction

  // Collect one full scan from both instances, keyed by the observed select.
  task automatic read_disp(output logic [63:0] s0, output logic [63:0] s1);
    s0 = 'x;
    s1 = 'x;
    repeat (8 * DIV) begin
      @(posedge in_clk); #1;
      for (int i = 0; i < 8; i++) begin
        if (o_sel  == ~(8'(1) << i)) s0[8*i +: 8] = o_seg;
        if (o_sel1 == ~(8'(1) << i)) s1[8*i +: 8] = o_seg1;
      end
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_busy && n < 60) begin
      @(posedge in_clk); #1;
      n++;
    end
  endtask

  // One-cycle request; leaves the bench #1 after the acceptance edge.
  task automatic launch(input logic [31:0] d, input bit expect_accept);
    @(negedge in_clk);
    in_data  = d;
    in_valid = 1'b1;
    if (expect_accept) exp_q.push_back(model_disp(d));
    @(posedge in_clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic test_reset;
    logic [63:0] s0, s1, e;
    in_rst = 1'b0;
    repeat (3) @(posedge in_clk);
    #1;
    checks += 4;
    if (o_seg !== 8'hFF)  begin errors++; $display("FAIL reset_seg got %h want ff", o_seg); end
    if (o_sel !== 8'hFF)  begin errors++; $display("FAIL reset_sel got %h want ff", o_sel); end
    if (o_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    if (o_sel1 !== 8'hFF) begin errors++; $display("FAIL reset_sel1 got %h want ff", o_sel1); end
    @(negedge in_clk);
    in_rst = 1'b1;
    exp_q.push_back(model_disp(32'h0));
    @(posedge in_clk); #1;
    checks += 3;
    if (o_sel !== 8'hFE)  begin errors++; $display("FAIL first_sel got %h want fe", o_sel); end
    if (o_seg !== 8'hC0)  begin errors++; $display("FAIL first_seg got %h want c0", o_seg); end
    if (o_sel1 !== 8'hFE) begin errors++; $display("FAIL first_sel1 got %h want fe", o_sel1); end
    read_disp(s0, s1);
    e = exp_q.pop_front();
    cur_exp = e;
    checks += 2;
    if (s0 !== e) begin errors++; $display("FAIL reset_disp got %h want %h", s0, e); end
    if (s1 !== e) begin errors++; $display("FAIL reset_disp1 got %h want %h", s1, e); end
  endtask

  task automatic test_convert(input string name, input logic [31:0] d);
    logic [63:0] s0, s1, e;
    int          n;
    launch(d, 1'b1);
    checks += 2;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL %s_busy_rise got %b want 1", name, o_busy); end
    wait_idle(n);
    if (n != 17) begin errors++; $display("FAIL %s_busy_len got %0d want 17", name, n); end
    read_disp(s0, s1);
    checks += 2;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard got empty want 1 entry", name);
    end else begin
      e = exp_q.pop_front();
      cur_exp = e;
      if (s0 !== e) begin errors++; $display("FAIL %s_disp got %h want %h", name, s0, e); end
      if (s1 !== e) begin errors++; $display("FAIL %s_disp1 got %h want %h", name, s1, e); end
    end
  endtask

  task automatic test_drop;
    logic [63:0] s0, s1, e;
    int          n;
    launch(32'h0001_0063, 1'b1);
    repeat (4) @(posedge in_clk);
    @(negedge in_clk);
    in_data  = 32'h2222_0BB8;
    in_valid = 1'b1;
    @(posedge in_clk); #1;
    in_valid = 1'b0;
    checks += 2;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL drop_busy got %b want 1", o_busy); end
    wait_idle(n);
    if (n != 12) begin errors++; $display("FAIL drop_busy_left got %0d want 12", n); end
    read_disp(s0, s1);
    e = exp_q.pop_front();
    cur_exp = e;
    checks += 2;
    if (s0 !== e) begin errors++; $display("FAIL drop_disp got %h want %h", s0, e); end
    if (s1 !== e) begin errors++; $display("FAIL drop_disp1 got %h want %h", s1, e); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] s0, s1, e;
    int          rises[$];
    logic        prev;
    int          n;
    @(negedge in_clk);
    in_data  = 32'h270F_0000;
    in_valid = 1'b1;
    exp_q.push_back(model_disp(32'h270F_0000));
    prev = o_busy;
    n = 0;
    while (rises.size() < 3 && n < 100) begin
      @(posedge in_clk); #1;
      if (o_busy && !prev) rises.push_back(cyc);
      prev = o_busy;
      n++;
    end
    @(negedge in_clk);
    in_valid = 1'b0;
    checks++;
    if (rises.size() != 3) begin
      errors++;
      $display("FAIL b2b_rises got %0d want 3", rises.size());
    end else begin
      checks += 2;
      if (rises[1] - rises[0] != 18)
        begin errors++; $display("FAIL b2b_period0 got %0d want 18", rises[1] - rises[0]); end
      if (rises[2] - rises[1] != 18)
        begin errors++; $display("FAIL b2b_period1 got %0d want 18", rises[2] - rises[1]); end
    end
    @(posedge in_clk); #1;
    wait_idle(n);
    read_disp(s0, s1);
    e = exp_q.pop_front();
    cur_exp = e;
    checks += 2;
    if (s0 !== e) begin errors++; $display("FAIL b2b_disp got %h want %h", s0, e); end
    if (s1 !== e) begin errors++; $display("FAIL b2b_disp1 got %h want %h", s1, e); end
  endtask

  // Select/segment checked on every cycle against a divider model counted from reset.
  task automatic test_scan;
    int         idx, idx1, bad_sel, bad_seg;
    logic [7:0] es;
    bad_sel = 0;
    bad_seg = 0;
    for (int i = 0; i < 48; i++) begin
      @(posedge in_clk); #1;
      idx  = ((cyc - 1) / DIV) % 8;
      idx1 = (cyc - 1) % 8;
      es   = cur_exp[8*idx +: 8];
      checks += 4;
      if (o_sel !== ~(8'(1) << idx)) begin
        errors++;
        $display("FAIL scan_sel cyc %0d got %h want %h", cyc, o_sel, ~(8'(1) << idx));
      end
      if (o_seg !== es) begin
        errors++;
        $display("FAIL scan_seg cyc %0d got %h want %h", cyc, o_seg, es);
      end
      es = cur_exp[8*idx1 +: 8];
      if (o_sel1 !== ~(8'(1) << idx1)) begin
        errors++;
        $display("FAIL scan1_sel cyc %0d got %h want %h", cyc, o_sel1, ~(8'(1) << idx1));
      end
      if (o_seg1 !== es) begin
        errors++;
        $display("FAIL scan1_seg cyc %0d got %h want %h", cyc, o_seg1, es);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] s0, s1, e;
    launch(32'h1234_5678, 1'b1);
    repeat (8) @(posedge in_clk);
    #1;
    in_rst = 1'b0;
    void'(exp_q.pop_back());
    exp_q.push_back(model_disp(32'h0));
    #1;
    checks += 4;
    if (o_busy !== 1'b0)  begin errors++; $display("FAIL abort_busy got %b want 0", o_busy); end
    if (o_busy1 !== 1'b0) begin errors++; $display("FAIL abort_busy1 got %b want 0", o_busy1); end
    if (o_seg !== 8'hFF)  begin errors++; $display("FAIL abort_seg got %h want ff", o_seg); end
    if (o_sel !== 8'hFF)  begin errors++; $display("FAIL abort_sel got %h want ff", o_sel); end
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    in_rst = 1'b1;
    read_disp(s0, s1);
    e = exp_q.pop_front();
    checks += 3;
    if (s0 !== e) begin errors++; $display("FAIL abort_disp got %h want %h", s0, e); end
    if (s1 !== e) begin errors++; $display("FAIL abort_disp1 got %h want %h", s1, e); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", o_busy); end
  endtask

  initial begin
    test_reset();
    test_convert("dec1111_1234", 32'h0457_04D2);
    test_convert("sat_right", 32'h0000_2710);
    test_convert("max", 32'hFFFF_FFFF);
    test_convert("edge9999", 32'h270F_0000);
    test_drop();
    test_back_to_back();
    test_scan();
    test_convert("small7", 32'h0000_0007);
    test_scan();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
